ce_pulse_gen: RTL
=================

CE_PULSE_GEN -- requirements
Module: ce_pulse_gen

Interface
REQ-001 Parameter DIV_W, default 16: width of the divide-ratio input.
REQ-002 Parameter CNT_W, default 8: width of the burst length and the pulse counter.
REQ-003 The block SHALL provide these ports:
  clk       in   1      clock, rising edge
  clr       in   1      reset, asynchronous, active-high
  sreset    in   1      synchronous reset, active-high
  div       in   DIV_W  divide ratio; one ce pulse per div+1 cycles
  mode      in   1      0 = continuous, 1 = burst
  burst_len in   CNT_W  number of ce pulses in burst mode
  start     in   1      begin generation (sampled in IDLE only)
  stop      in   1      abort generation
  ce        out  1      single-cycle clock-enable pulse to downstream flip-flops
  busy      out  1      generator running
  done      out  1      one-cycle pulse at burst completion
  tick_cnt  out  CNT_W  ce pulses issued since the last start

Function
REQ-004 The FSM SHALL have three states: IDLE, RUN and DONE. All outputs SHALL be registered.
REQ-005 IDLE->RUN SHALL occur at the edge E0 that samples start=1 and stop=0.
  - At E0, div, mode and burst_len SHALL be latched.
  - At E0, the prescaler and tick_cnt SHALL clear to 0, and busy SHALL be set to 1.
REQ-006 In RUN, with latched divide ratio D, ce SHALL be 1 for exactly the cycle following edge E0+k*(D+1), for k = 1, 2, ...
  - ce SHALL be 0 in all other cycles.
  - D=0 SHALL give ce=1 in every cycle from E0+1 onward.
REQ-007 tick_cnt SHALL increment at every edge that sets ce=1, wrapping modulo 2^CNT_W.
REQ-008 In burst mode with latched length L>0, the edge that issues pulse L SHALL stay in RUN.
  - At the next edge the FSM SHALL go to DONE, with ce=0, busy=0 and done=1.
  - At the edge after that it SHALL return to IDLE with done=0.
REQ-009 In burst mode with L=0, the FSM SHALL go RUN->DONE at edge E0+1 and issue no ce pulse.
REQ-010 Continuous mode SHALL stay in RUN until stop is asserted or a reset occurs.
REQ-011 stop=1 sampled in RUN or DONE SHALL force IDLE at that edge.
  - It SHALL suppress any ce pulse scheduled for that edge.
  - It SHALL clear busy and SHALL NOT assert done.
REQ-012 stop SHALL take priority over start when both are asserted in the same cycle.
REQ-013 start asserted while in RUN or DONE SHALL be ignored, and latched parameters SHALL NOT change.
REQ-014 Changes to div, mode or burst_len during RUN SHALL have no effect until the next start.
REQ-015 tick_cnt SHALL hold its value in IDLE and DONE.

Reset
REQ-016 clr=1 SHALL immediately force the following, independent of clk:
  - state IDLE, with ce=0, busy=0 and done=0;
  - tick_cnt=0, prescaler=0 and all latched parameters 0.
REQ-017 sreset=1 SHALL produce the same state as REQ-016 at the next rising edge.
  - sreset SHALL take priority over start, stop and all counting.
REQ-018 A reset asserted mid-burst SHALL abort the burst without a done pulse.
  - Generation SHALL resume only on a fresh start.

Structure
REQ-019 A shared package ce_pkg SHALL hold the FSM state type (IDLE, RUN, DONE) and the mode constants MODE_CONT=0 and MODE_BURST=1.
REQ-020 The prescaler SHALL be a separate sub-module, ce_prescaler.
  - It SHALL be a DIV_W-bit counter with clr, sync clear, enable, the latched divide ratio and a terminal-count output.
  - ce_pulse_gen SHALL instantiate it once.
REQ-021 The implementation SHALL contain no latches and no gated clocks; ce SHALL be used only as an enable downstream.

Verification
REQ-022 Continuous mode, div=3, start at E0 -> ce high after E4, E8 and E12; tick_cnt reads 3 after E12; busy=1 throughout.
REQ-023 Burst mode, div=1, burst_len=4 -> ce after E2, E4, E6 and E8; done=1 and busy=0 after E9; IDLE after E10; tick_cnt=4.
REQ-024 Burst mode, burst_len=0 -> no ce; done=1 after E1; IDLE after E2; tick_cnt=0.
REQ-025 Continuous mode, div=0, stop sampled at E5 together with start=1 -> ce high after E1 to E4, ce=0 after E5, IDLE, done never asserted, tick_cnt=4.
REQ-026 Burst mode, div=2, burst_len=5, clr pulsed asynchronously between E7 and E8 -> all outputs 0 immediately; a later start runs a full 5-pulse burst.
REQ-027 Burst mode with div changed to 9 after E0, and start re-asserted mid-burst -> pulse spacing stays at the original div+1 and the burst count is unaffected.

Source files
------------

// File: rtl/ce_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ce_pkg : shared FSM state type and mode constants for ce_pulse_gen   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ce_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_CONT  = 1'b0;
    localparam logic MODE_BURST = 1'b1;

endpackage
`default_nettype wire

// File: rtl/ce_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ce_prescaler : divide-by-(div+1) counter with terminal-count output  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ce_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sclr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tc
);

    logic [DIV_W-1:0] r_cnt;

    // Terminal count is seen on the edge that wraps the counter back to 0.
    assign tc = (r_cnt == div);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (sclr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= tc ? '0 : r_cnt + DIV_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ce_pulse_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ce_pulse_gen : clock-enable pulse generator, continuous or burst     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ce_pulse_gen
    import ce_pkg::*;
#(
    parameter int DIV_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sreset,
    input  logic [DIV_W-1:0] div,
    input  logic             mode,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             start,
    input  logic             stop,
    output logic             ce,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] tick_cnt
);

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic             r_mode;
    logic [CNT_W-1:0] r_len;
    logic             r_ce;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_tick;

    logic w_launch;
    logic w_tc;
    logic w_burst_end;

    assign w_launch    = (r_state == IDLE) && start && !stop;
    // tick count restarts at launch, so it equals the pulses issued in this burst
    assign w_burst_end = (r_mode == MODE_BURST) && (r_tick == r_len);

    ce_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk  (clk),
        .clr  (clr),
        .sclr (sreset | w_launch),
        .en   (r_state == RUN),
        .div  (r_div),
        .tc   (w_tc)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_mode  <= MODE_CONT;
            r_len   <= '0;
            r_ce    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_tick  <= '0;
        end else if (sreset) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_mode  <= MODE_CONT;
            r_len   <= '0;
            r_ce    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_tick  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ce   <= 1'b0;
                    r_done <= 1'b0;
                    if (w_launch) begin
                        r_state <= RUN;
                        r_div   <= div;
                        r_mode  <= mode;
                        r_len   <= burst_len;
                        r_tick  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        r_state <= IDLE;
                        r_ce    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else if (w_burst_end) begin
                        r_state <= DONE;
                        r_ce    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_ce <= w_tc;
                        if (w_tc) begin
                            r_tick <= r_tick + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_ce    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ce    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign ce       = r_ce;
    assign busy     = r_busy;
    assign done     = r_done;
    assign tick_cnt = r_tick;

endmodule
`default_nettype wire
